// File: rtl/spmv_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : spmv_mem_arb_if
// Description : Channel request/response and memory-port bundle for spmv_mem_arb
// Revision    : 1.0
// ============================================================================
interface spmv_mem_arb_if #(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 2
);
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RT      = CH_BITS + TAG_WIDTH;

  logic [CHANNELS-1:0]            ch_push;
  logic [CHANNELS-1:0]            ch_st;
  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr;
  logic [CHANNELS*DATA_WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]            ch_almost_full;

  logic                           req_mem_ld;
  logic                           req_mem_st;
  logic [ADDR_WIDTH-1:0]          req_mem_addr;
  logic [63:0]                    req_mem_d_or_tag;
  logic                           req_mem_stall;

  logic                           rsp_mem_push;
  logic [RT-1:0]                  rsp_mem_tag;
  logic [DATA_WIDTH-1:0]          rsp_mem_q;

  logic [CHANNELS-1:0]            ch_rsp_push;
  logic [TAG_WIDTH-1:0]           ch_rsp_tag;
  logic [DATA_WIDTH-1:0]          ch_rsp_q;
  logic [1:0]                     err;

  modport slave (
    input  ch_push, ch_st, ch_addr, ch_data, req_mem_stall,
           rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    output ch_almost_full, req_mem_ld, req_mem_st, req_mem_addr,
           req_mem_d_or_tag, ch_rsp_push, ch_rsp_tag, ch_rsp_q, err
  );

  modport master (
    output ch_push, ch_st, ch_addr, ch_data, req_mem_stall,
           rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    input  ch_almost_full, req_mem_ld, req_mem_st, req_mem_addr,
           req_mem_d_or_tag, ch_rsp_push, ch_rsp_tag, ch_rsp_q, err
  );
endinterface
`default_nettype wire

// File: rtl/spmv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : spmv_mem_arb
// Description : Per-channel request FIFOs, memory-port arbiter, response router
// Revision    : 1.0
// ============================================================================
module spmv_mem_arb #(
  parameter int CHANNELS          = 4,
  parameter int ADDR_WIDTH        = 48,
  parameter int DATA_WIDTH        = 64,
  parameter int TAG_WIDTH         = 2,
  parameter int FIFO_DEPTH        = 32,
  parameter int ALMOST_FULL_COUNT = 8,
  parameter int RR_MODE           = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  spmv_mem_arb_if.slave bus
);
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RT      = CH_BITS + TAG_WIDTH;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [AW:0] c_depth = (AW+1)'(FIFO_DEPTH);

  logic [CHANNELS-1:0] w_elig;
  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_af;
  logic [EW-1:0]       w_head [CHANNELS];
  logic                w_grant_vld;
  logic [CH_BITS-1:0]  w_grant_idx;
  logic [CH_BITS-1:0]  w_scan;
  logic [CH_BITS-1:0]  r_last;

  // Entry layout: {st, addr, data}
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;
    logic            r_af;
    logic            w_push_ok;
    logic            w_pop;

    assign w_full[g]  = (r_cnt == c_depth);
    assign w_push_ok  = bus.ch_push[g] && !w_full[g];
    assign w_pop      = w_grant_vld && (w_grant_idx == CH_BITS'(g));
    assign w_elig[g]  = (r_cnt != '0);
    assign w_head[g]  = r_mem[r_rd_ptr];
    assign w_af[g]    = r_af;

    always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push_ok, w_pop})
        2'b10:   w_cnt_nxt = r_cnt + 1'b1;
        2'b01:   w_cnt_nxt = r_cnt - 1'b1;
        default: w_cnt_nxt = r_cnt;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_af     <= 1'b0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cnt <= w_cnt_nxt;
        r_af  <= (32'(c_depth - w_cnt_nxt) <= 32'(ALMOST_FULL_COUNT));
      end
    end

    always_ff @(posedge clk) begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {bus.ch_st[g],
                            bus.ch_addr[g*ADDR_WIDTH +: ADDR_WIDTH],
                            bus.ch_data[g*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Fixed mode scans from 0; round-robin scans from the channel after the last winner
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    if (!bus.req_mem_stall) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (RR_MODE != 0) w_scan = CH_BITS'((int'(r_last) + 1 + k) % CHANNELS);
        else              w_scan = CH_BITS'(k);
        if (!w_grant_vld && w_elig[w_scan]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_scan;
        end
      end
    end
  end

  logic [EW-1:0]         w_sel;
  logic                  w_sel_st;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  assign w_sel      = w_head[w_grant_idx];
  assign w_sel_st   = w_sel[EW-1];
  assign w_sel_addr = w_sel[EW-2 -: ADDR_WIDTH];
  assign w_sel_data = w_sel[DATA_WIDTH-1:0];

  logic                  r_req_ld;
  logic                  r_req_st;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [63:0]           r_req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ld   <= 1'b0;
      r_req_st   <= 1'b0;
      r_req_addr <= '0;
      r_req_d    <= '0;
      r_last     <= CH_BITS'(CHANNELS - 1);
    end else begin
      r_req_ld <= w_grant_vld && !w_sel_st;
      r_req_st <= w_grant_vld && w_sel_st;
      if (w_grant_vld) begin
        r_last     <= w_grant_idx;
        r_req_addr <= w_sel_addr;
        // Load tag carries the channel index in the low bits so the response can be routed
        r_req_d    <= w_sel_st ? 64'(w_sel_data)
                               : 64'({w_sel_data[TAG_WIDTH-1:0], w_grant_idx});
      end
    end
  end

  logic [CH_BITS-1:0]    w_rsp_ch;
  logic                  w_rsp_ok;
  logic [CHANNELS-1:0]   r_rsp_push;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic [DATA_WIDTH-1:0] r_rsp_q;
  logic [1:0]            r_err;

  assign w_rsp_ch = bus.rsp_mem_tag[CH_BITS-1:0];
  assign w_rsp_ok = (32'(w_rsp_ch) < 32'(CHANNELS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_push <= '0;
      r_rsp_tag  <= '0;
      r_rsp_q    <= '0;
      r_err      <= '0;
    end else begin
      r_rsp_push <= '0;
      if (bus.rsp_mem_push && w_rsp_ok) begin
        r_rsp_push <= CHANNELS'(1) << w_rsp_ch;
        r_rsp_tag  <= bus.rsp_mem_tag[RT-1:CH_BITS];
        r_rsp_q    <= bus.rsp_mem_q;
      end
      r_err[0] <= r_err[0] | (|(bus.ch_push & w_full));
      r_err[1] <= r_err[1] | (bus.rsp_mem_push && !w_rsp_ok);
    end
  end

  assign bus.ch_almost_full   = w_af;
  assign bus.req_mem_ld       = r_req_ld;
  assign bus.req_mem_st       = r_req_st;
  assign bus.req_mem_addr     = r_req_addr;
  assign bus.req_mem_d_or_tag = r_req_d;
  assign bus.ch_rsp_push      = r_rsp_push;
  assign bus.ch_rsp_tag       = r_rsp_tag;
  assign bus.ch_rsp_q         = r_rsp_q;
  assign bus.err              = r_err;
endmodule
`default_nettype wire

// File: tb/tb_spmv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spmv_mem_arb
// Description : Scoreboard bench for spmv_mem_arb (fixed, round-robin, 3-channel)
// Revision    : 1.0
// ============================================================================
module tb_spmv_mem_arb;
  typedef struct packed {
    logic        st;
    logic [47:0] addr;
    logic [63:0] d;
    int          cyc;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  req_t q_fp[$];
  req_t q_rr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spmv_mem_arb_if #(.CHANNELS(4)) bus_fp ();
  spmv_mem_arb_if #(.CHANNELS(4)) bus_rr ();
  spmv_mem_arb_if #(.CHANNELS(3)) bus_c3 ();

  spmv_mem_arb #(.CHANNELS(4), .RR_MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));
  spmv_mem_arb #(.CHANNELS(4), .RR_MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
  spmv_mem_arb #(.CHANNELS(3), .RR_MODE(0)) u_c3 (.clk(clk), .rst_n(rst_n), .bus(bus_c3));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic st, input logic [47:0] a, input logic [63:0] d, input int c);
    req_t r;
    r.st = st; r.addr = a; r.d = d; r.cyc = c;
    return r;
  endfunction

  task automatic cmp_req(input string nm, input logic ld, input logic st,
                         input logic [47:0] a, input logic [63:0] d, input bit have, input req_t e);
    if (!have) begin
      chk({nm, "_unexpected_req"}, {ld, st}, 2'b00);
    end else begin
      chk({nm, "_kind"}, {ld, st}, {~e.st, e.st});
      chk({nm, "_addr"}, a, e.addr);
      chk({nm, "_data"}, d, e.d);
      chk({nm, "_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin : b_mon
    req_t e;
    bit   have;
    if (bus_fp.req_mem_ld || bus_fp.req_mem_st) begin
      have = (q_fp.size() != 0);
      e = have ? q_fp.pop_front() : '0;
      cmp_req("fp", bus_fp.req_mem_ld, bus_fp.req_mem_st, bus_fp.req_mem_addr, bus_fp.req_mem_d_or_tag, have, e);
    end
    if (bus_rr.req_mem_ld || bus_rr.req_mem_st) begin
      have = (q_rr.size() != 0);
      e = have ? q_rr.pop_front() : '0;
      cmp_req("rr", bus_rr.req_mem_ld, bus_rr.req_mem_st, bus_rr.req_mem_addr, bus_rr.req_mem_d_or_tag, have, e);
    end
    if (bus_c3.req_mem_ld || bus_c3.req_mem_st)
      chk("c3_unexpected_req", {bus_c3.req_mem_ld, bus_c3.req_mem_st}, 2'b00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus_fp.ch_push = '0; bus_fp.ch_st = '0; bus_fp.ch_addr = '0; bus_fp.ch_data = '0;
    bus_fp.req_mem_stall = 1'b0; bus_fp.rsp_mem_push = 1'b0; bus_fp.rsp_mem_tag = '0; bus_fp.rsp_mem_q = '0;
    bus_rr.ch_push = '0; bus_rr.ch_st = '0; bus_rr.ch_addr = '0; bus_rr.ch_data = '0;
    bus_rr.req_mem_stall = 1'b0; bus_rr.rsp_mem_push = 1'b0; bus_rr.rsp_mem_tag = '0; bus_rr.rsp_mem_q = '0;
    bus_c3.ch_push = '0; bus_c3.ch_st = '0; bus_c3.ch_addr = '0; bus_c3.ch_data = '0;
    bus_c3.req_mem_stall = 1'b0; bus_c3.rsp_mem_push = 1'b0; bus_c3.rsp_mem_tag = '0; bus_c3.rsp_mem_q = '0;
  endtask

  task automatic drv_push(input int ch, input logic st, input logic [47:0] a, input logic [63:0] d);
    bus_fp.ch_push[ch] = 1'b1; bus_fp.ch_st[ch] = st;
    bus_fp.ch_addr[ch*48 +: 48] = a; bus_fp.ch_data[ch*64 +: 64] = d;
    bus_rr.ch_push[ch] = 1'b1; bus_rr.ch_st[ch] = st;
    bus_rr.ch_addr[ch*48 +: 48] = a; bus_rr.ch_data[ch*64 +: 64] = d;
  endtask

  task automatic clr_push();
    bus_fp.ch_push = '0;
    bus_rr.ch_push = '0;
  endtask

  task automatic set_stall(input logic s);
    bus_fp.req_mem_stall = s;
    bus_rr.req_mem_stall = s;
  endtask

  task automatic exp_both(input logic st, input logic [47:0] a, input logic [63:0] d, input int c);
    q_fp.push_back(mk(st, a, d, c));
    q_rr.push_back(mk(st, a, d, c));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (q_fp.size() != 0 || q_rr.size() != 0); i++) tick();
    repeat (3) tick();
    chk("drain_fp", q_fp.size(), 0);
    chk("drain_rr", q_rr.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  localparam logic [63:0] c_ld_data = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    int c0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fp_ctl", {bus_fp.ch_almost_full, bus_fp.req_mem_ld, bus_fp.req_mem_st, bus_fp.ch_rsp_push, bus_fp.err}, '0);
    chk("rst_fp_bus", {bus_fp.req_mem_addr, bus_fp.req_mem_d_or_tag}, '0);
    chk("rst_fp_rsp", {bus_fp.ch_rsp_tag, bus_fp.ch_rsp_q}, '0);
    chk("rst_rr_ctl", {bus_rr.ch_almost_full, bus_rr.req_mem_ld, bus_rr.req_mem_st, bus_rr.ch_rsp_push, bus_rr.err}, '0);
    chk("rst_c3_ctl", {bus_c3.ch_almost_full, bus_c3.req_mem_ld, bus_c3.req_mem_st, bus_c3.ch_rsp_push, bus_c3.err}, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two loads on every channel, the second a cycle after the first
    c0 = cyc;
    for (int ch = 0; ch < 4; ch++) drv_push(ch, 1'b0, 48'(ch*256), c_ld_data);
    for (int k = 0; k < 8; k++) begin
      q_fp.push_back(mk(1'b0, 48'((k/2)*256 + k%2), 64'(k/2), c0 + 2 + k));
      q_rr.push_back(mk(1'b0, 48'((k%4)*256 + k/4), 64'(k%4), c0 + 2 + k));
    end
    tick();
    for (int ch = 0; ch < 4; ch++) drv_push(ch, 1'b0, 48'(ch*256 + 1), c_ld_data);
    tick();
    clr_push();
    wait_drain();

    // Stores on channel 1; stall rises while the first is already on the port
    c0 = cyc;
    drv_push(1, 1'b1, 48'h1A0, 64'hAAAA_0000_0000_0001);
    exp_both(1'b1, 48'h1A0, 64'hAAAA_0000_0000_0001, c0 + 2);
    tick();
    drv_push(1, 1'b1, 48'h1A1, 64'hBBBB_0000_0000_0002);
    exp_both(1'b1, 48'h1A1, 64'hBBBB_0000_0000_0002, c0 + 8);
    tick();
    drv_push(1, 1'b1, 48'h1A2, 64'hCCCC_0000_0000_0003);
    exp_both(1'b1, 48'h1A2, 64'hCCCC_0000_0000_0003, c0 + 9);
    set_stall(1'b1);
    tick();
    clr_push();
    repeat (4) tick();
    set_stall(1'b0);
    wait_drain();

    // Fill channel 0 past its depth with the memory port stalled
    c0 = cyc;
    set_stall(1'b1);
    for (int k = 0; k < 33; k++) begin
      drv_push(0, 1'b1, 48'(32'h1000 + k), 64'(32'hA5A5_0000 + k));
      if (k < 32) exp_both(1'b1, 48'(32'h1000 + k), 64'(32'hA5A5_0000 + k), c0 + 34 + k);
      tick();
      if (k == 22 || k == 23 || k == 31 || k == 32) begin
        chk($sformatf("af_fp_after_push%0d", k + 1), bus_fp.ch_almost_full, {3'b000, (k + 1 >= 24)});
        chk($sformatf("err_fp_after_push%0d", k + 1), bus_fp.err, (k == 32) ? 2'b01 : 2'b00);
      end
    end
    chk("af_rr_full", bus_rr.ch_almost_full, 4'b0001);
    chk("err_rr_overflow", bus_rr.err, 2'b01);
    clr_push();
    set_stall(1'b0);
    wait_drain();

    // Response routing, including a bad index on the 3-channel instance
    bus_fp.rsp_mem_push = 1'b1; bus_fp.rsp_mem_tag = 4'b1011; bus_fp.rsp_mem_q = 64'hDEAD;
    bus_c3.rsp_mem_push = 1'b1; bus_c3.rsp_mem_tag = 4'b0011; bus_c3.rsp_mem_q = 64'h1234;
    tick();
    chk("rt_fp_push", bus_fp.ch_rsp_push, 4'b1000);
    chk("rt_fp_tag", bus_fp.ch_rsp_tag, 2'd2);
    chk("rt_fp_q", bus_fp.ch_rsp_q, 64'hDEAD);
    chk("rt_c3_badpush", bus_c3.ch_rsp_push, 3'b000);
    chk("rt_c3_err", bus_c3.err, 2'b10);
    bus_fp.rsp_mem_tag = 4'b0100; bus_fp.rsp_mem_q = 64'hBEEF;
    bus_c3.rsp_mem_tag = 4'b1110; bus_c3.rsp_mem_q = 64'h55;
    tick();
    chk("rt_fp_push2", bus_fp.ch_rsp_push, 4'b0001);
    chk("rt_fp_tag2", bus_fp.ch_rsp_tag, 2'd1);
    chk("rt_fp_q2", bus_fp.ch_rsp_q, 64'hBEEF);
    chk("rt_c3_push2", bus_c3.ch_rsp_push, 3'b100);
    chk("rt_c3_tag2", bus_c3.ch_rsp_tag, 2'd3);
    chk("rt_c3_err_sticky", bus_c3.err, 2'b10);
    bus_fp.rsp_mem_push = 1'b0;
    bus_c3.rsp_mem_push = 1'b0;
    tick();
    chk("rt_fp_pulse_end", bus_fp.ch_rsp_push, 4'b0000);
    chk("err_fp_sticky", bus_fp.err, 2'b01);

    // Reset while a request is on the port and another waits in the FIFO
    c0 = cyc;
    drv_push(3, 1'b0, 48'h3000, c_ld_data);
    exp_both(1'b0, 48'h3000, 64'h3, c0 + 2);
    tick();
    drv_push(3, 1'b0, 48'h3001, c_ld_data);
    tick();
    drv_push(3, 1'b0, 48'h3002, c_ld_data);
    tick();
    clr_push();
    chk("pre_rst_fp_ld", bus_fp.req_mem_ld, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_fp", {bus_fp.ch_almost_full, bus_fp.req_mem_ld, bus_fp.req_mem_st, bus_fp.ch_rsp_push, bus_fp.err}, '0);
    chk("mid_rst_fp_bus", {bus_fp.req_mem_addr, bus_fp.req_mem_d_or_tag}, '0);
    chk("mid_rst_rr", {bus_rr.req_mem_ld, bus_rr.req_mem_st, bus_rr.err}, '0);
    chk("mid_rst_c3_err", bus_c3.err, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    c0 = cyc;
    drv_push(2, 1'b0, 48'h2222, 64'hF0F0_0000_0000_0001);
    exp_both(1'b0, 48'h2222, 64'h6, c0 + 2);
    tick();
    clr_push();
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
`default_nettype wire
